// File: rtl/seven_scan.sv
// seven_scan: time-multiplexed scan controller for an N-digit common-anode
// seven-segment display. Double-buffered digit codes, blanking gap before
// each digit, optional leading-zero suppression, active-low digit selects.
module seven_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [5*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_sup,
    output logic [4:0]            code_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     sel_n,
    output logic                  frame_done
);

    localparam int unsigned CODE_W  = 5;
    localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  BLANK_END  = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0]  SHOW_END   = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h1F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_d;

    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_d;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_d;

    logic [CODE_W*DIGITS-1:0]   pend_code;
    logic [DIGITS-1:0]          pend_dp;
    logic [CODE_W*DIGITS-1:0]   act_code;
    logic [DIGITS-1:0]          act_dp;
    logic [CODE_W*DIGITS-1:0]   act_code_d;
    logic [DIGITS-1:0]          act_dp_d;

    logic                       swap;
    logic                       ld_slot;
    logic                       fd_d;
    logic                       upper_zero;
    logic [CODE_W-1:0]          slot_code;
    logic                       slot_dp;

    logic [CODE_W-1:0]          code_d;
    logic                       dp_d;
    logic [DIGITS-1:0]          sel_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: dropping en always returns to IDLE on the next clock
    always_comb begin
        state_d = state;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_d = S_BLANK;
                S_BLANK: if (cnt == BLANK_END) state_d = S_SHOW;
                S_SHOW:  if (cnt == SHOW_END)  state_d = S_BLANK;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Slot sequencing: counter, digit index, frame boundary and swap request
    always_comb begin
        cnt_d   = cnt;
        idx_d   = idx;
        swap    = 1'b0;
        ld_slot = 1'b0;
        fd_d    = 1'b0;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    swap    = 1'b1;
                    ld_slot = 1'b1;
                end
                S_BLANK: begin
                    if (cnt == BLANK_END) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_END) begin
                        cnt_d   = '0;
                        ld_slot = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_d = '0;
                            swap  = 1'b1;
                            fd_d  = 1'b1;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            endcase
        end
    end

    // Next active buffer and the code/dp for the digit about to be blanked-in;
    // newest load wins on a swap cycle, leading zeros scanned from the top down
    always_comb begin
        act_code_d = act_code;
        act_dp_d   = act_dp;
        if (swap) begin
            act_code_d = load ? digits_in : pend_code;
            act_dp_d   = load ? dp_in     : pend_dp;
        end
        upper_zero = 1'b1;
        slot_code  = CODE_BLANK;
        slot_dp    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (act_code_d[CODE_W*i +: CODE_W] == 5'd0) & ~act_dp_d[i];
            if (IDX_W'(i) == idx_d) begin
                if (lz_sup && (i != 0) && upper_zero) begin
                    slot_code = CODE_BLANK;
                    slot_dp   = 1'b0;
                end else begin
                    slot_code = act_code_d[CODE_W*i +: CODE_W];
                    slot_dp   = act_dp_d[i];
                end
            end
        end
    end

    // Output next-values: selects follow the slot phase, code/dp change only on
    // blank entry so they are settled before the digit is selected
    always_comb begin
        sel_d  = sel_n;
        code_d = code_out;
        dp_d   = dp_out;
        if (!en) begin
            sel_d  = '1;
            code_d = CODE_BLANK;
            dp_d   = 1'b0;
        end else begin
            case (state)
                S_IDLE:  sel_d = '1;
                S_BLANK: if (cnt == BLANK_END) sel_d = ~(DIGITS'(1) << idx);
                S_SHOW:  if (cnt == SHOW_END)  sel_d = '1;
                default: sel_d = '1;
            endcase
            if (ld_slot) begin
                code_d = slot_code;
                dp_d   = slot_dp;
            end
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_d;
            idx <= idx_d;
        end
    end

    // Pending buffer: captured on any load strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_code <= '0;
            pend_dp   <= '0;
        end else if (load) begin
            pend_code <= digits_in;
            pend_dp   <= dp_in;
        end
    end

    // Active buffer: only changes at a frame boundary so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_code <= '0;
            act_dp   <= '0;
        end else begin
            act_code <= act_code_d;
            act_dp   <= act_dp_d;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_n      <= '1;
            code_out   <= CODE_BLANK;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel_n      <= sel_d;
            code_out   <= code_d;
            dp_out     <= dp_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: doc/seven_scan.md
Name: seven_scan

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds a double-buffered set of 5-bit digit codes and per-digit decimal-point bits.
- Steps through the digits one at a time, feeding each code and dp bit to the single shared hex-digit decoder and driving the active-low digit selects.
- Inserts an all-off blanking gap before each digit to prevent ghosting.
- Sits between the application logic (counters, status registers) and the decoder / board pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
DIV, 50000, clock cycles each digit is lit (SHOW time, >=1)
BLANK, 500, clock cycles all digits are off before each digit (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = scanning enabled; 0 = display dark
load  in  1  1-cycle strobe: capture digits_in/dp_in into the pending buffer
digits_in  in  5*DIGITS  digit codes; digit i at [5i+4:5i]; digit 0 is rightmost
dp_in  in  DIGITS  decimal-point request per digit
lz_sup  in  1  1 = blank leading zeros
code_out  out  5  code to the decoder; 5'h1F = blank (decoder default)
dp_out  out  1  dp bit to the decoder
sel_n  out  DIGITS  digit enables, active low, at most one bit low
frame_done  out  1  1-cycle pulse when the last digit's SHOW slot ends

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- On reset: state IDLE, sel_n all 1, code_out 5'h1F, dp_out 0, frame_done 0, digit index 0, counter 0.
  - Pending and active buffers: codes 0, dp 0.
- All outputs are registered.
- Pending buffer: written on any cycle with load=1, regardless of en or state.
- Active buffer (drives the outputs) is copied from pending only at a frame boundary, so a frame never tears:
  - on IDLE->BLANK entry;
  - on the last digit's SHOW->BLANK wrap to digit 0.
  - If load=1 on the boundary cycle, the active buffer takes digits_in/dp_in directly (newest data wins).
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: en=1 -> BLANK with idx=0 and counter cleared.
  - BLANK: sel_n all 1. code_out/dp_out are loaded on entry with digit idx's values, so they are stable before select.
    - After BLANK cycles -> SHOW.
  - SHOW: sel_n[idx]=0, all other sel_n bits 1.
    - After DIV cycles: if idx < DIGITS-1, idx+1 and -> BLANK.
    - Otherwise idx=0, frame_done=1 for that one transition cycle, buffer swap, -> BLANK.
- Frame length: DIGITS*(BLANK+DIV) cycles.
- en=0 in any state: IDLE on the next clock.
  - sel_n all 1, code_out 5'h1F, dp_out 0, idx 0, counter 0, no frame_done.
  - Re-enabling always restarts at digit 0 with BLANK.
- Leading-zero suppression, when lz_sup=1 and digit i>0:
  - The digit is suppressed if every digit j with i<=j<=DIGITS-1 has code 0 and dp 0.
  - A suppressed digit outputs code_out=5'h1F, dp_out=0, and sel_n is still asserted for timing uniformity.
  - Digit 0 is never suppressed.
- Codes 16..31 pass through unmodified; only code 0 counts as a zero for suppression.
- Counter width: clog2(max(DIV,BLANK)) bits, with no wrap beyond its terminal count.
- Reset asserted mid-slot: all outputs go to their reset values immediately, without waiting for clk.

Test Plan:
Run with DIGITS=4, DIV=4, BLANK=2, so a frame is 24 cycles.
1. Reset, en=1, load digits 3,2,1,0 = 4,3,2,1 (hex), dp=0 -> code_out sequence 1,2,3,4. sel_n goes 1110,1101,1011,0111, each low for 4 cycles and preceded by 2 cycles of 1111. frame_done pulses every 24 cycles.
2. Load 0,0,0,5 with lz_sup=1 -> digits 3..1 give code_out 1F and digit 0 gives 5. With lz_sup=0 -> 0,0,0,5. With dp_in=0100 and lz_sup=1 -> digit 2 shows code 0 with dp_out=1, and digit 3 stays blank.
3. load pulse mid-frame (during digit 1 SHOW) -> digits 2 and 3 of the current frame still show old values; new values appear from digit 0 of the next frame. load on the frame_done cycle -> those values are used in the very next frame.
4. Drop en during digit 2 SHOW -> next cycle sel_n=1111, code_out=1F, no frame_done. Re-raise en -> 2 BLANK cycles, then digit 0 lit.
5. Assert rst_n=0 asynchronously between clock edges during SHOW -> sel_n=1111 and code_out=1F immediately. Active buffer cleared: after release with en=1, digit 0 shows code 0.
6. Check over 3 frames: never more than one sel_n bit low; sel_n=1111 for exactly 2 cycles before every digit change.
